// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution sequencer.
package conv_pkg;

  localparam int unsigned ADDR_W_DEF    = 12;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned MAX_COUNT_DEF = 4095;

  localparam int unsigned CNT_ADDR      = 0;
  localparam int unsigned WGT_ADDR      = 0;
  localparam int unsigned FIRST_IN_ADDR = 1;

  localparam int unsigned RESULT_W      = 4;
  localparam int unsigned WEIGHT_W      = 9;
  localparam int unsigned IN_W          = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CNT,
    S_LATCH_CNT,
    S_RD_IN,
    S_LATCH_IN,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // Busy covers every state of a batch except the final DONE cycle.
  function automatic logic is_busy_state(input state_t s);
    return !((s == S_IDLE) || (s == S_DONE));
  endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// conv_seq_addr_gen: word index counter and SRAM address generation.
module conv_seq_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_count,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_rd_next_c,
  output logic [ADDR_W-1:0] o_wr_addr_c,
  output logic              o_last_c
);

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_count;

  // Index starts at the first input word; it stops at N so it never wraps.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_idx   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_idx   <= ADDR_W'(FIRST_IN_ADDR);
      r_count <= i_count;
    end else if (i_inc && !o_last_c) begin
      r_idx   <= r_idx + ADDR_W'(1);
    end
  end

  assign o_last_c    = (r_idx == r_count);
  assign o_rd_next_c = r_idx + ADDR_W'(1);
  assign o_wr_addr_c = r_idx - ADDR_W'(1);

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: walks a batch of 4x4 input words through conv_engine and
// stores each 4-bit feature map. Optional macro CONV_SEQ_PREFETCH_EN reads
// the next input word while the engine is busy, saving two cycles per word.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                dut_run,
  output logic                dut_busy,
  output logic [ADDR_W-1:0]   dut_sram_read_address,
  input  logic [DATA_W-1:0]   sram_dut_read_data,
  output logic [ADDR_W-1:0]   dut_wmem_read_address,
  input  logic [DATA_W-1:0]   wmem_dut_read_data,
  output logic [ADDR_W-1:0]   dut_sram_write_address,
  output logic [DATA_W-1:0]   dut_sram_write_data,
  output logic                dut_sram_write_enable,
  output logic                eng_start,
  output logic [IN_W-1:0]     eng_in,
  output logic [WEIGHT_W-1:0] eng_weight,
  input  logic                eng_done,
  input  logic [RESULT_W-1:0] eng_result
);

  state_t              r_state, w_state_nxt;
  logic                r_busy, w_busy_nxt;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic [ADDR_W-1:0]   r_wmem_addr;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic                r_start, w_start_nxt;
  logic [IN_W-1:0]     r_eng_in, w_eng_in_nxt;
  logic [WEIGHT_W-1:0] r_weight, w_weight_nxt;

  logic                w_load;
  logic                w_inc;
  logic [ADDR_W-1:0]   w_rd_next;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_last;

  logic [ADDR_W-1:0]   w_cnt_raw;
  logic [ADDR_W-1:0]   w_count;
  logic                w_cnt_over;
  logic                w_unused_wmem;

  // Count word lives in the low address-width bits; clamp to MAX_COUNT.
  assign w_cnt_raw     = sram_dut_read_data[ADDR_W-1:0];
  assign w_cnt_over    = ((ADDR_W+1)'(w_cnt_raw) > (ADDR_W+1)'(MAX_COUNT));
  assign w_count       = w_cnt_over ? ADDR_W'(MAX_COUNT) : w_cnt_raw;
  assign w_unused_wmem = ^wmem_dut_read_data[DATA_W-1:WEIGHT_W];

  conv_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset_b     (reset_b),
    .i_load      (w_load),
    .i_count     (w_count),
    .i_inc       (w_inc),
    .o_rd_next_c (w_rd_next),
    .o_wr_addr_c (w_wr_addr),
    .o_last_c    (w_last)
  );

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_wr_en_nxt   = 1'b0;
    w_start_nxt   = 1'b0;
    w_eng_in_nxt  = r_eng_in;
    w_weight_nxt  = r_weight;
    w_load        = 1'b0;
    w_inc         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (dut_run) w_state_nxt = S_RD_CNT;
      end
      S_RD_CNT: begin
        w_state_nxt = S_LATCH_CNT;
      end
      S_LATCH_CNT: begin
        w_load       = 1'b1;
        w_weight_nxt = wmem_dut_read_data[WEIGHT_W-1:0];
        if (w_count == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt   = S_RD_IN;
          w_rd_addr_nxt = ADDR_W'(FIRST_IN_ADDR);
        end
      end
      S_RD_IN: begin
        w_state_nxt = S_LATCH_IN;
      end
      S_LATCH_IN: begin
        w_eng_in_nxt = sram_dut_read_data[IN_W-1:0];
        w_state_nxt  = S_START;
      end
      S_START: begin
        w_state_nxt = S_WAIT;
`ifdef CONV_SEQ_PREFETCH_EN
        if (!w_last) w_rd_addr_nxt = w_rd_next;
`endif
      end
      S_WAIT: begin
        if (eng_done) begin
          w_wr_data_nxt = DATA_W'(eng_result);
          w_wr_addr_nxt = w_wr_addr;
          w_state_nxt   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_inc = 1'b1;
`ifdef CONV_SEQ_PREFETCH_EN
          // Address idx+1 has been stable since WAIT began, so data is valid now.
          w_eng_in_nxt = sram_dut_read_data[IN_W-1:0];
          w_state_nxt  = S_START;
`else
          w_rd_addr_nxt = w_rd_next;
          w_state_nxt   = S_RD_IN;
`endif
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_RD_CNT)) begin
      w_rd_addr_nxt = ADDR_W'(CNT_ADDR);
    end
    w_busy_nxt  = is_busy_state(w_state_nxt);
    w_start_nxt = (w_state_nxt == S_START);
    w_wr_en_nxt = (w_state_nxt == S_WRITE);
  end

  // State and output registers; reset aborts a batch without writing.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_rd_addr   <= '0;
      r_wmem_addr <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_start     <= 1'b0;
      r_eng_in    <= '0;
      r_weight    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_wmem_addr <= ADDR_W'(WGT_ADDR);
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_start     <= w_start_nxt;
      r_eng_in    <= w_eng_in_nxt;
      r_weight    <= w_weight_nxt;
    end
  end

  assign dut_busy               = r_busy;
  assign dut_sram_read_address  = r_rd_addr;
  assign dut_wmem_read_address  = r_wmem_addr;
  assign dut_sram_write_address = r_wr_addr;
  assign dut_sram_write_data    = r_wr_data;
  assign dut_sram_write_enable  = r_wr_en;
  assign eng_start              = r_start;
  assign eng_in                 = r_eng_in;
  assign eng_weight             = r_weight;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench with SRAM models and a 2-cycle engine stub.
module tb_conv_sequencer;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned LOG_D = 8192;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          dut_run = 1'b0;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [DW-1:0] sram_dut_read_data = '0;
  logic [AW-1:0] dut_wmem_read_address;
  logic [DW-1:0] wmem_dut_read_data = '0;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;
  logic          dut_sram_write_enable;
  logic          eng_start;
  logic [15:0]   eng_in;
  logic [8:0]    eng_weight;
  logic          eng_done = 1'b0;
  logic [3:0]    eng_result = '0;

  conv_sequencer #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_COUNT (4095)
  ) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .eng_start              (eng_start),
    .eng_in                 (eng_in),
    .eng_weight             (eng_weight),
    .eng_done               (eng_done),
    .eng_result             (eng_result)
  );

  always #5 clk = ~clk;

  // Binary 3x3 convolution over a 4x4 word: output bit set when >=5 of 9 taps match.
  function automatic logic [3:0] conv_ref(input logic [15:0] x, input logic [8:0] w);
    logic [3:0] r;
    int m;
    r = '0;
    for (int r0 = 0; r0 < 2; r0++) begin
      for (int c0 = 0; c0 < 2; c0++) begin
        m = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            if (x[(r0 + i) * 4 + c0 + j] == w[i * 3 + j]) m++;
          end
        end
        r[r0 * 2 + c0] = (m >= 5);
      end
    end
    return r;
  endfunction

  function automatic int exp_busy(input int n);
    if (n == 0) return 2;
`ifdef CONV_SEQ_PREFETCH_EN
    return 2 + 6 + 4 * (n - 1);
`else
    return 2 + 6 * n;
`endif
  endfunction

  // Input SRAM and weight SRAM: one-cycle read latency.
  logic [15:0] isram [0:4095];
  logic [15:0] wmem0 = '0;
  always @(posedge clk) begin
    sram_dut_read_data <= isram[dut_sram_read_address];
    wmem_dut_read_data <= (dut_wmem_read_address == 12'd0) ? wmem0 : 16'hDEAD;
  end

  // Engine stub: eng_done two cycles after the start pulse.
  logic       eng_p1 = 1'b0;
  logic       eng_stray = 1'b0;
  logic [3:0] eng_r1 = '0;
  always @(posedge clk) begin
    eng_p1     <= eng_start;
    eng_r1     <= conv_ref(eng_in, eng_weight);
    eng_done   <= eng_p1 | eng_stray;
    eng_result <= eng_r1;
  end

  // Monitor: busy cycles, writes and engine starts, sampled mid-cycle.
  int          busy_cnt = 0;
  int          wr_cnt = 0;
  int          st_cnt = 0;
  logic [11:0] wr_addr_log [0:LOG_D-1];
  logic [15:0] wr_data_log [0:LOG_D-1];
  logic [15:0] st_in_log   [0:LOG_D-1];
  logic [8:0]  st_w_log    [0:LOG_D-1];
  always @(negedge clk) begin
    if (dut_busy) busy_cnt++;
    if (dut_sram_write_enable && wr_cnt < int'(LOG_D)) begin
      wr_addr_log[wr_cnt] = dut_sram_write_address;
      wr_data_log[wr_cnt] = dut_sram_write_data;
      wr_cnt++;
    end
    if (eng_start && st_cnt < int'(LOG_D)) begin
      st_in_log[st_cnt] = eng_in;
      st_w_log[st_cnt]  = eng_weight;
      st_cnt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(dut_busy), 0);
    check({tag, "_rdadr"}, 32'(dut_sram_read_address), 0);
    check({tag, "_wmadr"}, 32'(dut_wmem_read_address), 0);
    check({tag, "_wradr"}, 32'(dut_sram_write_address), 0);
    check({tag, "_wrdat"}, 32'(dut_sram_write_data), 0);
    check({tag, "_we"},    32'(dut_sram_write_enable), 0);
    check({tag, "_start"}, 32'(eng_start), 0);
    check({tag, "_engin"}, 32'(eng_in), 0);
    check({tag, "_wgt"},   32'(eng_weight), 0);
  endtask

  task automatic pulse_run();
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
  endtask

  // Wait for busy to rise and then fall (the DONE cycle), bounded.
  task automatic wait_done(input string tag, input int max_c);
    bit seen;
    bit fin;
    seen = 1'b0;
    fin  = 1'b0;
    for (int c = 0; c < max_c && !fin; c++) begin
      @(negedge clk);
      if (dut_busy) seen = 1'b1;
      else if (seen) fin = 1'b1;
    end
    check({tag, "_done"}, 32'(fin), 1);
  endtask

  task automatic run_batch(input string tag, input int max_c, output int bc);
    int b0;
    b0 = busy_cnt;
    pulse_run();
    wait_done(tag, max_c);
    bc = busy_cnt - b0;
  endtask

  task automatic load_words(input logic [15:0] cnt, input logic [15:0] w,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    isram[0] = cnt;
    isram[1] = a;
    isram[2] = b;
    isram[3] = c;
    isram[4] = d;
    wmem0    = w;
  endtask

  int bc, w0, s0, b0, nst;
  logic [15:0] t3_in  [0:2];
  logic [15:0] t3_out [0:2];
  logic [15:0] t4_in  [0:3];

  initial begin
    for (int i = 0; i < 4096; i++) isram[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    @(negedge clk) reset_b = 1'b1;
    repeat (2) @(posedge clk);

    // N=0: count and weight fetched, no engine activity
    load_words(16'h0000, 16'hA1FF, 16'h0, 16'h0, 16'h0, 16'h0);
    w0 = wr_cnt; s0 = st_cnt;
    run_batch("n0", 50, bc);
    check("n0_busy", 32'(bc), 2);
    check("n0_writes", 32'(wr_cnt - w0), 0);
    check("n0_starts", 32'(st_cnt - s0), 0);
    check("n0_weight", 32'(eng_weight), 32'h1FF);

    // N=1: all-ones word against all-ones weight yields 4'hF
    load_words(16'h0001, 16'h01FF, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    w0 = wr_cnt;
    run_batch("n1", 50, bc);
    check("n1_busy", 32'(bc), 8);
    check("n1_writes", 32'(wr_cnt - w0), 1);
    check("n1_addr", 32'(wr_addr_log[w0]), 0);
    check("n1_data", 32'(wr_data_log[w0]), 32'h000F);

    // Stray eng_done while idle has no effect
    w0 = wr_cnt; b0 = busy_cnt;
    @(posedge clk); #1 eng_stray = 1'b1;
    @(posedge clk); #1 eng_stray = 1'b0;
    repeat (4) @(posedge clk);
    check("stray_writes", 32'(wr_cnt - w0), 0);
    check("stray_busy", 32'(busy_cnt - b0), 0);

    // N=3 with hand-computed results (weight all ones)
    t3_in[0] = 16'h0000; t3_out[0] = 16'h0000;
    t3_in[1] = 16'hFFFF; t3_out[1] = 16'h000F;
    t3_in[2] = 16'h00FF; t3_out[2] = 16'h0003;
    load_words(16'h0003, 16'h01FF, t3_in[0], t3_in[1], t3_in[2], 16'h0);
    w0 = wr_cnt; s0 = st_cnt;
    run_batch("n3", 100, bc);
    check("n3_busy", 32'(bc), 32'(exp_busy(3)));
    check("n3_writes", 32'(wr_cnt - w0), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("n3_addr%0d", k), 32'(wr_addr_log[w0 + k]), 32'(k));
      check($sformatf("n3_data%0d", k), 32'(wr_data_log[w0 + k]), 32'(t3_out[k]));
      check($sformatf("n3_engin%0d", k), 32'(st_in_log[s0 + k]), 32'(t3_in[k]));
      check($sformatf("n3_wgt%0d", k), 32'(st_w_log[s0 + k]), 32'h1FF);
    end

    // dut_run pulsed during WAIT is ignored
    load_words(16'h0002, 16'h00AB, 16'h1234, 16'hCAFE, 16'h0, 16'h0);
    w0 = wr_cnt; b0 = busy_cnt;
    pulse_run();
    nst = 0;
    for (int c = 0; c < 50 && nst == 0; c++) begin
      @(negedge clk);
      if (eng_start) nst++;
    end
    check("mid_start_seen", 32'(nst), 1);
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    wait_done("mid", 100);
    check("mid_busy", 32'(busy_cnt - b0), 32'(exp_busy(2)));
    b0 = busy_cnt;
    repeat (6) @(negedge clk);
    check("mid_no_requeue", 32'(busy_cnt - b0), 0);
    check("mid_writes", 32'(wr_cnt - w0), 2);
    check("mid_data0", 32'(wr_data_log[w0]), 32'(conv_ref(16'h1234, 9'h0AB)));
    check("mid_data1", 32'(wr_data_log[w0 + 1]), 32'(conv_ref(16'hCAFE, 9'h0AB)));

    // dut_run held: relaunch follows a single IDLE cycle after DONE
    w0 = wr_cnt; b0 = busy_cnt;
    @(posedge clk); #1 dut_run = 1'b1;
    wait_done("hold1", 100);
    check("hold1_busy", 32'(busy_cnt - b0), 32'(exp_busy(2)));
    @(negedge clk);
    check("hold_idle_busy", 32'(dut_busy), 0);
    @(negedge clk);
    check("hold_relaunch_busy", 32'(dut_busy), 1);
    check("hold_relaunch_rdadr", 32'(dut_sram_read_address), 0);
    @(posedge clk); #1 dut_run = 1'b0;
    wait_done("hold2", 100);
    check("hold_writes", 32'(wr_cnt - w0), 4);
    check("hold_addr3", 32'(wr_addr_log[w0 + 3]), 1);

    // Reset during WAIT of word 2 aborts with only address 0 written
    load_words(16'h0003, 16'h01FF, t3_in[0], t3_in[1], t3_in[2], 16'h0);
    w0 = wr_cnt;
    pulse_run();
    nst = 0;
    for (int c = 0; c < 100 && nst < 2; c++) begin
      @(negedge clk);
      if (eng_start) nst++;
    end
    check("rstmid_start2", 32'(nst), 2);
    @(posedge clk); #1 reset_b = 1'b0;
    #1 check_zero("rstmid");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_b = 1'b1;
    check("rstmid_writes", 32'(wr_cnt - w0), 1);
    check("rstmid_addr", 32'(wr_addr_log[w0]), 0);
    repeat (4) @(posedge clk);
    w0 = wr_cnt;
    run_batch("rerun", 100, bc);
    check("rerun_busy", 32'(bc), 32'(exp_busy(3)));
    check("rerun_writes", 32'(wr_cnt - w0), 3);
    check("rerun_addr2", 32'(wr_addr_log[w0 + 2]), 2);
    check("rerun_data2", 32'(wr_data_log[w0 + 2]), 32'h0003);

    // N=4, count upper bits ignored; busy depends on prefetch build
    t4_in[0] = 16'h8001; t4_in[1] = 16'h7E7E; t4_in[2] = 16'h0F0F; t4_in[3] = 16'hA5A5;
    load_words(16'hF004, 16'hFF55, t4_in[0], t4_in[1], t4_in[2], t4_in[3]);
    w0 = wr_cnt; s0 = st_cnt;
    run_batch("n4", 100, bc);
    check("n4_busy", 32'(bc), 32'(exp_busy(4)));
    check("n4_writes", 32'(wr_cnt - w0), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("n4_addr%0d", k), 32'(wr_addr_log[w0 + k]), 32'(k));
      check($sformatf("n4_data%0d", k), 32'(wr_data_log[w0 + k]), 32'(conv_ref(t4_in[k], 9'h155)));
      check($sformatf("n4_engin%0d", k), 32'(st_in_log[s0 + k]), 32'(t4_in[k]));
    end

    // N=4095: last word at address 4095, last write at 4094, no wrap
    isram[0] = 16'hFFFF;
    for (int i = 1; i < 4096; i++) isram[i] = 16'(i * 40503);
    wmem0 = 16'h00F3;
    w0 = wr_cnt;
    run_batch("nmax", 30000, bc);
    check("nmax_busy", 32'(bc), 32'(exp_busy(4095)));
    check("nmax_writes", 32'(wr_cnt - w0), 4095);
    check("nmax_first_addr", 32'(wr_addr_log[w0]), 0);
    check("nmax_last_addr", 32'(wr_addr_log[w0 + 4094]), 32'h0FFE);
    check("nmax_last_data", 32'(wr_data_log[w0 + 4094]), 32'(conv_ref(isram[4095], 9'h0F3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Sequences the single-window binary convolution engine over a batch of 4x4 input words held in input SRAM.
- Per batch: fetches the word count and the 3x3 weight, feeds each input word to the engine, and writes each 4-bit feature map to output SRAM.
- Sits between the top-level run/busy control and conv_engine; owns all SRAM address generation.

Parameters:
- ADDR_W, 12, SRAM address width
- DATA_W, 16, SRAM data width
- MAX_COUNT, 4095, upper clamp on batch word count

Ports:
- clk  in  1  clock
- reset_b  in  1  reset; asynchronous, active-low
- dut_run  in  1  start request, sampled in IDLE only
- dut_busy  out  1  high while a batch is in progress
- dut_sram_read_address  out  ADDR_W  input SRAM read address
- sram_dut_read_data  in  DATA_W  input SRAM read data
- dut_wmem_read_address  out  ADDR_W  weight SRAM read address
- wmem_dut_read_data  in  DATA_W  weight SRAM read data
- dut_sram_write_address  out  ADDR_W  output SRAM write address
- dut_sram_write_data  out  DATA_W  output SRAM write data
- dut_sram_write_enable  out  1  output SRAM write strobe
- eng_start  out  1  one-cycle start pulse to conv_engine
- eng_in  out  16  input word to engine, held stable from eng_start until eng_done
- eng_weight  out  9  weight to engine, stable for the whole batch
- eng_done  in  1  engine result valid, one-cycle pulse
- eng_result  in  4  engine feature map

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE.
- SRAM timing: read data is valid in the cycle after the address is driven and is sampled at the end of that cycle.
- Memory map:
  - Input SRAM address 0 holds the count N in bits [11:0]; bits [15:12] are ignored.
  - Input words are at addresses 1..N.
  - Weight is at wmem address 0, bits [8:0].
  - Outputs are written to addresses 0..N-1.
  - N is clamped to MAX_COUNT.
- States:
  - IDLE: if dut_run, go to RD_CNT. Read addresses are 0.
  - RD_CNT: dut_busy=1. Both read addresses are 0.
  - LATCH_CNT: capture N and weight; idx<=1. If N==0, go to DONE; else go to RD_IN.
  - RD_IN: dut_sram_read_address=idx.
  - LATCH_IN: eng_in<=read data.
  - START: eng_start=1 for exactly one cycle.
  - WAIT: hold until eng_done.
  - WRITE: write_enable=1 for one cycle; address=idx-1; data={12'b0, eng_result captured at eng_done}. If idx==N, go to DONE; else idx++ and go to RD_IN.
  - DONE: dut_busy=0, write_enable=0; go to IDLE.
- Per-word cost: 4 cycles plus engine latency (cycles spent in WAIT, at least 1).
- Boundary conditions:
  - dut_run outside IDLE is ignored; no queuing.
  - dut_run held high re-launches a batch on the cycle after DONE.
  - eng_done outside WAIT is ignored.
  - eng_done in the same cycle WAIT is entered completes WAIT.
  - N=4095 is the last address; idx never wraps.
  - Reset mid-batch aborts immediately with no partial write; output contents already written are retained.

Optional Feature:
- Macro: CONV_SEQ_PREFETCH_EN.
- Defined:
  - In WAIT, the next word is read (address idx+1) into a prefetch register when idx<N.
  - WRITE goes directly to START with eng_in<=prefetch, skipping RD_IN and LATCH_IN.
  - Per-word cost becomes 2 cycles plus engine latency.
  - Writes and results are identical to the undefined case.
- Undefined: sequencing exactly as in Behaviour.

Decomposition:
- Shared package conv_pkg:
  - state encoding enum
  - ADDR_W and DATA_W defaults
  - CNT_ADDR=0, WGT_ADDR=0, FIRST_IN_ADDR=1
  - RESULT_W=4
- Sub-module conv_seq_addr_gen:
  - idx counter with load, increment and terminal-count compare against N
  - produces read and write addresses

Test Plan:
- Engine model with fixed 2-cycle latency.
- N=0, weight 9'h1FF, dut_run pulse:
  - busy high for exactly 2 cycles (RD_CNT, LATCH_CNT), then DONE.
  - Zero writes, zero eng_start.
- N=1, in[1]=16'hFFFF, weight 9'h1FF, engine returns 4'hF:
  - one write, addr 0, data 16'h000F.
  - busy high 8 cycles.
- N=3, distinct words:
  - writes to addrs 0, 1, 2 in order, each data matching the model.
  - eng_in matches in[1..3].
  - eng_weight constant throughout.
- dut_run pulsed during WAIT and held through DONE:
  - mid-batch pulse ignored.
  - new batch starts the cycle after DONE.
- reset_b asserted during WAIT of word 2, N=3:
  - all outputs 0 asynchronously.
  - only addr 0 was written.
  - next dut_run restarts cleanly from count fetch.
- CONV_SEQ_PREFETCH_EN, N=4:
  - identical write data and addresses to the undefined build.
  - total busy cycles reduced by 2×3=6.
